// File: rtl/alu_exer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_exer_pkg
// Brief    : Shared types, widths and the signature step for the ALU exerciser.
// Revision : 1.0 - initial release
// ============================================================================
package alu_exer_pkg;

    localparam int ALU_OP_W = 4;
    localparam int DATA_W   = 32;
    localparam int FLG_W    = 3;

    localparam int FLG_OF = 2;
    localparam int FLG_CF = 1;
    localparam int FLG_EQ = 0;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRIVE  = 3'd1,
        SAMPLE = 3'd2,
        EMIT   = 3'd3,
        DONE   = 3'd4
    } state_t;

    // Rotate-left-by-one MISR step; result2 halves are swapped so that
    // result and result2 bits land on different signature positions.
    function automatic logic [DATA_W-1:0] sig_next(
        input logic [DATA_W-1:0] sig,
        input logic [DATA_W-1:0] res,
        input logic [DATA_W-1:0] res2,
        input logic [FLG_W-1:0]  flags
    );
        return {sig[DATA_W-2:0], sig[DATA_W-1]}
             ^ res
             ^ {res2[15:0], res2[31:16]}
             ^ {{(DATA_W-FLG_W){1'b0}}, flags};
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_exer_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_exer_if
// Brief    : Response-record stream (valid/ready) from the ALU exerciser.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_exer_if;
    import alu_exer_pkg::*;

    logic                rec_valid;
    logic                rec_ready;
    logic [ALU_OP_W-1:0] rec_op;
    logic [DATA_W-1:0]   rec_result;
    logic [DATA_W-1:0]   rec_result2;
    logic [FLG_W-1:0]    rec_flags;

    modport master (
        output rec_valid, rec_op, rec_result, rec_result2, rec_flags,
        input  rec_ready
    );

    modport slave (
        input  rec_valid, rec_op, rec_result, rec_result2, rec_flags,
        output rec_ready
    );

endinterface
`default_nettype wire

// File: rtl/alu_exer_misr.sv
`default_nettype none
// ============================================================================
// Module   : alu_exer_misr
// Brief    : 32-bit response signature register; only built with ALU_EXER_SIG_EN.
// Revision : 1.0 - initial release
// ============================================================================
`ifdef ALU_EXER_SIG_EN
module alu_exer_misr
    import alu_exer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr,
    input  logic              i_en,
    input  logic [DATA_W-1:0] i_result,
    input  logic [DATA_W-1:0] i_result2,
    input  logic [FLG_W-1:0]  i_flags,
    output logic [DATA_W-1:0] o_sig
);

    logic [DATA_W-1:0] r_sig;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_sig <= '0;
        end else if (i_en) begin
            r_sig <= sig_next(r_sig, i_result, i_result2, i_flags);
        end
    end

    assign o_sig = r_sig;

endmodule
`endif
`default_nettype wire

// File: rtl/alu_exerciser.sv
`default_nettype none
// ============================================================================
// Module   : alu_exerciser
// Brief    : ALU self-test sweep: drives every opcode, streams responses and
//            (with ALU_EXER_SIG_EN defined) folds them into a signature.
// Revision : 1.0 - initial release
// ============================================================================
module alu_exerciser
    import alu_exer_pkg::*;
#(
    parameter int NUM_OPS    = 13,
    parameter int SETTLE_CYC = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [DATA_W-1:0]   x_in,
    input  logic [DATA_W-1:0]   y_in,
    output logic                busy,
    output logic                done,
    output logic [DATA_W-1:0]   alu_x,
    output logic [DATA_W-1:0]   alu_y,
    output logic [ALU_OP_W-1:0] alu_op,
    input  logic [DATA_W-1:0]   alu_result,
    input  logic [DATA_W-1:0]   alu_result2,
    input  logic                alu_of,
    input  logic                alu_cf,
    input  logic                alu_equal,
    alu_exer_if.master          rec,
    output logic [DATA_W-1:0]   signature
);

    localparam int                  c_CNT_W       = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [c_CNT_W-1:0]  c_SETTLE_LAST = c_CNT_W'(SETTLE_CYC - 1);
    localparam logic [ALU_OP_W-1:0] c_LAST_OP     = ALU_OP_W'(NUM_OPS - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DATA_W-1:0]   r_x;
    logic [DATA_W-1:0]   r_y;
    logic [ALU_OP_W-1:0] r_op;
    logic [c_CNT_W-1:0]  r_settle_cnt;
    logic [DATA_W-1:0]   r_rec_result;
    logic [DATA_W-1:0]   r_rec_result2;
    logic [FLG_W-1:0]    r_rec_flags;
    logic [FLG_W-1:0]    w_flags;
    logic                w_start_acc;
    logic                w_sample;
    logic                w_advance;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start_acc = 1'b0;
        w_sample    = 1'b0;
        w_advance   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_start_acc = 1'b1;
                    w_state_nxt = DRIVE;
                end
            end
            DRIVE: begin
                if (r_settle_cnt == c_SETTLE_LAST) begin
                    w_state_nxt = SAMPLE;
                end
            end
            SAMPLE: begin
                w_sample    = 1'b1;
                w_state_nxt = EMIT;
            end
            EMIT: begin
                if (rec.rec_ready) begin
                    if (r_op == c_LAST_OP) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_advance   = 1'b1;
                        w_state_nxt = DRIVE;
                    end
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_flags         = '0;
        w_flags[FLG_OF] = alu_of;
        w_flags[FLG_CF] = alu_cf;
        w_flags[FLG_EQ] = alu_equal;
    end

    // Operands and opcode only move on start/advance, so they hold steady
    // from DRIVE through the end of EMIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x           <= '0;
            r_y           <= '0;
            r_op          <= '0;
            r_settle_cnt  <= '0;
            r_rec_result  <= '0;
            r_rec_result2 <= '0;
            r_rec_flags   <= '0;
        end else begin
            if (w_start_acc) begin
                r_x  <= x_in;
                r_y  <= y_in;
                r_op <= '0;
            end else if (w_advance) begin
                r_op <= r_op + ALU_OP_W'(1);
            end

            if (r_state == DRIVE) begin
                r_settle_cnt <= r_settle_cnt + c_CNT_W'(1);
            end else begin
                r_settle_cnt <= '0;
            end

            if (w_sample) begin
                r_rec_result  <= alu_result;
                r_rec_result2 <= alu_result2;
                r_rec_flags   <= w_flags;
            end
        end
    end

    assign busy            = (r_state != IDLE);
    assign done            = (r_state == DONE);
    assign alu_x           = r_x;
    assign alu_y           = r_y;
    assign alu_op          = r_op;
    assign rec.rec_valid   = (r_state == EMIT);
    assign rec.rec_op      = r_op;
    assign rec.rec_result  = r_rec_result;
    assign rec.rec_result2 = r_rec_result2;
    assign rec.rec_flags   = r_rec_flags;

`ifdef ALU_EXER_SIG_EN
    alu_exer_misr u_misr (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (w_start_acc),
        .i_en      (w_sample),
        .i_result  (alu_result),
        .i_result2 (alu_result2),
        .i_flags   (w_flags),
        .o_sig     (signature)
    );
`else
    assign signature = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_exerciser.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_exerciser
// Brief    : Self-checking bench for alu_exerciser with an XOR-based ALU stub.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_alu_exerciser;
    import alu_exer_pkg::*;

    localparam int NOPS = 13;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, start2, start3, flip_en;
    logic [31:0] x_in, y_in;

    // main instance
    logic        busy, done, alu_of, alu_cf, alu_equal;
    logic [31:0] alu_x, alu_y, alu_result, alu_result2, signature;
    logic [3:0]  alu_op;
    alu_exer_if  rec_if ();

    assign alu_result  = alu_x ^ {28'd0, alu_op} ^ {31'd0, flip_en && (alu_op == 4'd12)};
    assign alu_result2 = alu_y;
    assign alu_of      = alu_op[0];
    assign alu_cf      = alu_op[1];
    assign alu_equal   = (alu_op == 4'd0);

    alu_exerciser #(.NUM_OPS(NOPS), .SETTLE_CYC(1)) dut (
        .clk(clk), .rst(rst), .start(start), .x_in(x_in), .y_in(y_in),
        .busy(busy), .done(done), .alu_x(alu_x), .alu_y(alu_y), .alu_op(alu_op),
        .alu_result(alu_result), .alu_result2(alu_result2),
        .alu_of(alu_of), .alu_cf(alu_cf), .alu_equal(alu_equal),
        .rec(rec_if), .signature(signature)
    );

    // slow-settle instance
    logic        busy2, done2;
    logic [31:0] alu_x2, alu_y2, sig2;
    logic [3:0]  alu_op2;
    alu_exer_if  rec2_if ();
    assign rec2_if.rec_ready = 1'b1;

    alu_exerciser #(.NUM_OPS(NOPS), .SETTLE_CYC(3)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .x_in(32'd4), .y_in(32'd2),
        .busy(busy2), .done(done2), .alu_x(alu_x2), .alu_y(alu_y2), .alu_op(alu_op2),
        .alu_result(alu_x2 ^ {28'd0, alu_op2}), .alu_result2(alu_y2),
        .alu_of(alu_op2[0]), .alu_cf(alu_op2[1]), .alu_equal(alu_op2 == 4'd0),
        .rec(rec2_if), .signature(sig2)
    );

    // single-opcode instance
    logic        busy3, done3;
    logic [31:0] alu_x3, alu_y3, sig3;
    logic [3:0]  alu_op3;
    alu_exer_if  rec3_if ();
    assign rec3_if.rec_ready = 1'b1;

    alu_exerciser #(.NUM_OPS(1), .SETTLE_CYC(1)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .x_in(32'd4), .y_in(32'd2),
        .busy(busy3), .done(done3), .alu_x(alu_x3), .alu_y(alu_y3), .alu_op(alu_op3),
        .alu_result(alu_x3 ^ {28'd0, alu_op3}), .alu_result2(alu_y3),
        .alu_of(alu_op3[0]), .alu_cf(alu_op3[1]), .alu_equal(alu_op3 == 4'd0),
        .rec(rec3_if), .signature(sig3)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Reference behaviour of the stub ALU and of the signature recurrence.
    function automatic logic [31:0] m_res(input logic [31:0] x, input int op, input bit flip);
        return x ^ 32'(op) ^ ((flip && op == 12) ? 32'd1 : 32'd0);
    endfunction

    function automatic logic [2:0] m_flags(input int op);
        return {op[0], op[1], op == 0};
    endfunction

    function automatic logic [31:0] m_sig(input logic [31:0] x, input logic [31:0] y,
                                          input int nops, input bit flip);
        logic [31:0] s;
        s = 32'd0;
`ifdef ALU_EXER_SIG_EN
        for (int op = 0; op < nops; op++) begin
            s = ((s << 1) | (s >> 31)) ^ m_res(x, op, flip) ^ ((y << 16) | (y >> 16))
              ^ 32'(m_flags(op));
        end
`endif
        return s;
    endfunction

    logic [31:0] cap_res [16];
    logic [31:0] cap_res2[16];
    logic [3:0]  cap_op  [16];
    logic [2:0]  cap_flg [16];
    int          n_cap;

    // stall_len < 0 selects random rec_ready; otherwise hold ready low for
    // stall_len EMIT cycles at opcode stall_op.
    task automatic run_sweep(input logic [31:0] x, input logic [31:0] y, input int stall_op,
                             input int stall_len, input bit disturb, input bit flip);
        int   busy_cyc, done_cnt, wait_cyc, stall_cnt, err_xy, err_op, stab_err;
        bit   finished, pend;
        logic [3:0]  prev_op;
        logic [70:0] prev_pl, cur_pl;
        busy_cyc = 0; done_cnt = 0; wait_cyc = 0; stall_cnt = 0;
        err_xy = 0; err_op = 0; stab_err = 0; finished = 0; pend = 0;
        prev_op = 4'd0; prev_pl = '0; n_cap = 0;
        flip_en = flip;
        @(negedge clk);
        x_in = x; y_in = y; start = 1'b1; rec_if.rec_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        check("op_after_start", 32'(alu_op), 32'd0);
        for (int cyc = 0; cyc < 600 && !finished; cyc++) begin
            if (disturb && alu_op == 4'd6) begin
                start = 1'b1; x_in = 32'hFFFF_FFFF; y_in = ~y;
            end else begin
                start = 1'b0;
            end
            if (busy && !done) busy_cyc++;
            if (done) done_cnt++;
            if (busy && (alu_x !== x || alu_y !== y)) err_xy++;
            if (busy && alu_op !== prev_op && 32'(alu_op) !== 32'(prev_op) + 1) err_op++;
            prev_op = alu_op;
            cur_pl = {rec_if.rec_op, rec_if.rec_result, rec_if.rec_result2, rec_if.rec_flags};
            if (pend && (!rec_if.rec_valid || cur_pl !== prev_pl)) stab_err++;
            if (stall_len < 0) begin
                rec_if.rec_ready = ($urandom_range(0, 2) != 0);
            end else if (rec_if.rec_valid && int'(rec_if.rec_op) == stall_op && stall_cnt < stall_len) begin
                rec_if.rec_ready = 1'b0;
                stall_cnt++;
            end else begin
                rec_if.rec_ready = 1'b1;
            end
            if (rec_if.rec_valid && rec_if.rec_ready) begin
                if (n_cap < 16) begin
                    cap_op[n_cap]   = rec_if.rec_op;
                    cap_res[n_cap]  = rec_if.rec_result;
                    cap_res2[n_cap] = rec_if.rec_result2;
                    cap_flg[n_cap]  = rec_if.rec_flags;
                end
                n_cap++;
                pend = 0;
            end else if (rec_if.rec_valid) begin
                wait_cyc++;
                pend = 1;
                prev_pl = cur_pl;
            end
            if (done) finished = 1;
            @(negedge clk);
        end
        start = 1'b0;
        rec_if.rec_ready = 1'b1;
        check("sweep_finished", 32'(finished), 32'd1);
        check("busy_drop_after_done", 32'(busy), 32'd0);
        check("done_single_cycle", 32'(done), 32'd0);
        check("done_count", 32'(done_cnt), 32'd1);
        check("record_count", 32'(n_cap), 32'(NOPS));
        check("busy_cycles", 32'(busy_cyc), 32'(NOPS * 3 + wait_cyc));
        check("operand_stable", 32'(err_xy), 32'd0);
        check("op_no_skip", 32'(err_op), 32'd0);
        check("payload_stable", 32'(stab_err), 32'd0);
        for (int i = 0; i < NOPS && i < n_cap; i++) begin
            check($sformatf("rec%0d_op", i), 32'(cap_op[i]), 32'(i));
            check($sformatf("rec%0d_result", i), cap_res[i], m_res(x, i, flip));
            check($sformatf("rec%0d_result2", i), cap_res2[i], y);
            check($sformatf("rec%0d_flags", i), 32'(cap_flg[i]), 32'(m_flags(i)));
        end
        check("signature", signature, m_sig(x, y, NOPS, flip));
    endtask

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        int          op;
        logic [31:0] exp_res;
        logic [31:0] exp_res2;
        logic [2:0]  exp_flg;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int hold2[16];
        int busy2_cyc, hold_err, busy3_cyc;
        bit fin;

        vecs[0] = '{32'd4,          32'd2,          5,  32'h0000_0001, 32'h0000_0002, 3'b100};
        vecs[1] = '{32'd4,          32'd2,          0,  32'h0000_0004, 32'h0000_0002, 3'b001};
        vecs[2] = '{32'd4,          32'd2,          12, 32'h0000_0008, 32'h0000_0002, 3'b000};
        vecs[3] = '{32'hA5A5_A5A5,  32'hDEAD_BEEF,  3,  32'hA5A5_A5A6, 32'hDEAD_BEEF, 3'b110};
        vecs[4] = '{32'hFFFF_FFFF,  32'h0000_0000,  10, 32'hFFFF_FFF5, 32'h0000_0000, 3'b010};

        rst = 1'b1; start = 1'b0; start2 = 1'b0; start3 = 1'b0;
        x_in = '0; y_in = '0; flip_en = 1'b0; rec_if.rec_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rec_valid", 32'(rec_if.rec_valid), 32'd0);
        check("rst_alu_op", 32'(alu_op), 32'd0);
        check("rst_alu_x", alu_x, 32'd0);
        check("rst_alu_y", alu_y, 32'd0);
        check("rst_rec_result", rec_if.rec_result, 32'd0);
        check("rst_signature", signature, 32'd0);
        rst = 1'b0;

        // reset and start together: reset wins
        @(negedge clk);
        rst = 1'b1; start = 1'b1; x_in = 32'h1234_5678;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        check("rst_beats_start_busy", 32'(busy), 32'd0);
        check("rst_beats_start_x", alu_x, 32'd0);

        for (int i = 0; i < 5; i++) begin
            run_sweep(vecs[i].x, vecs[i].y, 3, (i == 0) ? 5 : 0, i == 1, 1'b0);
            check($sformatf("vec%0d_result", i), cap_res[vecs[i].op], vecs[i].exp_res);
            check($sformatf("vec%0d_result2", i), cap_res2[vecs[i].op], vecs[i].exp_res2);
            check($sformatf("vec%0d_flags", i), 32'(cap_flg[vecs[i].op]), 32'(vecs[i].exp_flg));
        end

        for (int r = 0; r < 6; r++) begin
            run_sweep($urandom, $urandom, 0, -1, r[0], 1'b0);
        end

        // flipped stub result at the last opcode
        run_sweep(32'd4, 32'd2, 0, 0, 1'b0, 1'b1);
        flip_en = 1'b0;

        // reset in the middle of a sweep
        @(negedge clk);
        x_in = 32'd4; y_in = 32'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        fin = 0;
        for (int c = 0; c < 200 && !fin; c++) begin
            if (alu_op == 4'd7) fin = 1;
            else @(negedge clk);
        end
        check("reached_op7", 32'(fin), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_rec_valid", 32'(rec_if.rec_valid), 32'd0);
        check("midrst_alu_op", 32'(alu_op), 32'd0);
        check("midrst_signature", signature, 32'd0);
        check("midrst_alu_x", alu_x, 32'd0);
        rst = 1'b0;
        run_sweep(32'd4, 32'd2, 0, 0, 1'b0, 1'b0);

        // settle of three cycles per opcode
        for (int i = 0; i < 16; i++) hold2[i] = 0;
        busy2_cyc = 0; hold_err = 0; fin = 0;
        @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        for (int c = 0; c < 300 && !fin; c++) begin
            if (busy2 && !done2) busy2_cyc++;
            if (busy2 && !done2 && !rec2_if.rec_valid) hold2[alu_op2]++;
            if (done2) fin = 1;
            @(negedge clk);
        end
        for (int i = 0; i < NOPS; i++) if (hold2[i] != 4) hold_err++;
        check("settle3_finished", 32'(fin), 32'd1);
        check("settle3_busy_cycles", 32'(busy2_cyc), 32'd65);
        check("settle3_op0_hold", 32'(hold2[0]), 32'd4);
        check("settle3_hold_all", 32'(hold_err), 32'd0);
        check("settle3_busy_drop", 32'(busy2), 32'd0);

        // single-opcode sweep and its signature
        busy3_cyc = 0; fin = 0;
        @(negedge clk);
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        for (int c = 0; c < 50 && !fin; c++) begin
            if (busy3 && !done3) busy3_cyc++;
            if (rec3_if.rec_valid) begin
                check("one_op_rec_op", 32'(rec3_if.rec_op), 32'd0);
                check("one_op_result", rec3_if.rec_result, 32'h0000_0004);
                check("one_op_result2", rec3_if.rec_result2, 32'h0000_0002);
                check("one_op_flags", 32'(rec3_if.rec_flags), 32'd1);
            end
            if (done3) fin = 1;
            @(negedge clk);
        end
        check("one_op_finished", 32'(fin), 32'd1);
        check("one_op_busy_cycles", 32'(busy3_cyc), 32'd3);
`ifdef ALU_EXER_SIG_EN
        check("one_op_signature", sig3, 32'h0002_0005);
`else
        check("one_op_signature", sig3, 32'h0000_0000);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_exerciser.md
# alu_exerciser

Synthesizable ALU built-in self-test engine for the single-cycle MIPS datapath. On `start` it latches an operand pair and drives it to the ALU once per opcode, from 0 up to NUM_OPS-1. For each opcode it samples `result`, `result2`, `of`, `cf` and `equal`, then streams that response out as a record over a valid/ready interface. It also folds every response into a 32-bit signature, so the whole ALU can be checked in-system against a golden value.

## Interface
Parameters:
- NUM_OPS, 13: opcodes swept, 0..NUM_OPS-1; legal range 1..16.
- SETTLE_CYC, 1: cycles operands/opcode are held before sampling; must be ≥1.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a sweep; honoured only in IDLE.
- x_in  in  32  operand x, latched on accepted start.
- y_in  in  32  operand y, latched on accepted start.
- busy  out  1  high from the cycle after an accepted start through DONE.
- done  out  1  one-cycle pulse at sweep end.
- alu_x  out  32  operand to ALU `x`.
- alu_y  out  32  operand to ALU `y`.
- alu_op  out  4  opcode to ALU `alu_op`.
- alu_result  in  32  ALU `result`.
- alu_result2  in  32  ALU `result2`.
- alu_of  in  1  ALU overflow flag.
- alu_cf  in  1  ALU carry flag.
- alu_equal  in  1  ALU equal flag.
- rec_valid  out  1  record available.
- rec_ready  in  1  consumer accepts record.
- rec_op  out  4  opcode of the record.
- rec_result  out  32  captured `result`.
- rec_result2  out  32  captured `result2`.
- rec_flags  out  3  captured {of, cf, equal}.
- signature  out  32  running response signature.

## Operation
- States:
  - IDLE: start=1 latches x_in/y_in, clears signature, sets op=0, → DRIVE.
  - DRIVE: alu_x/alu_y/alu_op driven from latched values; stays SETTLE_CYC cycles, → SAMPLE.
  - SAMPLE: captures ALU outputs into record registers, updates signature, → EMIT.
  - EMIT: rec_valid=1; on rec_valid&rec_ready, if op==NUM_OPS-1 → DONE, else op+1 → DRIVE.
  - DONE: done=1 for one cycle, → IDLE.
- Signature update (in SAMPLE): sig ← {sig[30:0],sig[31]} ^ result ^ {result2[15:0],result2[31:16]} ^ {29'd0,of,cf,equal}.
- Operands and opcode stay stable from DRIVE through EMIT; alu_op never skips or repeats within a sweep.
- start is ignored outside IDLE. x_in/y_in changes after the accepted start have no effect.
- Valid/ready rules:
  - once rec_valid rises, the record payload stays constant until the handshake;
  - rec_valid never drops without a handshake;
  - rec_ready may be high before rec_valid.
- Reset values: busy, done, rec_valid = 0; alu_x, alu_y, alu_op, rec_* = 0; signature = 0; state IDLE.
- rst mid-sweep: the next cycle shows reset values; any partial record is discarded.
- rst and start in the same cycle: rst wins.

## Timing
- Accepted start at edge N: busy=1 and alu_op=0 from N+1.
- Each opcode occupies SETTLE_CYC cycles in DRIVE, 1 in SAMPLE, and ≥1 in EMIT.
- With rec_ready held high, a sweep takes NUM_OPS·(SETTLE_CYC+2) cycles plus 1 DONE cycle; defaults give 39+1.
- The record and signature are registered: visible the cycle after SAMPLE.
- busy drops the cycle after done.
- A new start is accepted in the cycle after DONE, i.e. back in IDLE.

## Configuration
- ALU_EXER_SIG_EN defined: signature logic present and behaves as above.
- ALU_EXER_SIG_EN undefined: signature is tied to 32'd0, with no signature registers; records and handshake are unaffected.

## Structure
- Package alu_exer_pkg holds:
  - the state enum (IDLE, DRIVE, SAMPLE, EMIT, DONE);
  - ALU_OP_W=4 and DATA_W=32;
  - flag bit indices FLG_OF=2, FLG_CF=1, FLG_EQ=0.
- Sub-module alu_exer_misr holds the signature register, with clear, enable, and data/flags inputs. It is instantiated only under ALU_EXER_SIG_EN.

## Test plan
Bench ALU stub: result = x ^ op, result2 = y, flags = {op[0], op[1], op==0}.
- Basic sweep: x_in=4, y_in=2, start, rec_ready=1 → 13 records, ops 0..12 in order; op 5 record is result=0x00000001, result2=0x00000002, flags=3'b100; done pulses exactly once; busy high 39 cycles.
- Backpressure: rec_ready=0 for 5 cycles at op 3 → rec_valid stays high, payload and alu_op=3 stable, op 4 follows with no skip.
- Start rules: start while busy is ignored; x_in changed to 0xFFFFFFFF mid-sweep leaves alu_x=4 throughout.
- Reset mid-run: rst at op 7 → next cycle busy=0, rec_valid=0, alu_op=0, signature=0; the next start begins at op 0.
- Signature (ALU_EXER_SIG_EN, NUM_OPS=1, x=4, y=2) → signature=0x00020005.
- Signature sensitivity: two identical default sweeps give identical signatures; flipping stub result bit 0 at op 12 changes the signature.
- Settle: SETTLE_CYC=3 → each alu_op is held 3 cycles before SAMPLE; sweep takes 65+1 cycles.
